// File: rtl/dual_cbf_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dual_cbf_tracker                                                |
// | Purpose  : Row-activation tracker built from two counting Bloom filters.   |
// |            One filter answers queries. Both filters count inserts. At each |
// |            epoch boundary the filters swap roles and the old one is        |
// |            cleared one counter per cycle.                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module dual_cbf_tracker #(
  parameter int ROW_W      = 16,
  parameter int TID_W      = 3,
  parameter int NUM_CTR    = 1024,
  parameter int CTR_W      = 16,
  parameter int NUM_HASH   = 4,
  parameter int THRESHOLD  = 4096,
  parameter int EPOCH_ACTS = 32768
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ins_valid,
  output logic             ins_ready,
  input  logic [ROW_W-1:0] ins_row,
  input  logic [TID_W-1:0] ins_tid,
  input  logic             q_valid,
  input  logic [ROW_W-1:0] q_row,
  input  logic [TID_W-1:0] q_tid,
  output logic             resp_valid,
  output logic             resp_hit,
  output logic [CTR_W-1:0] resp_count,
  output logic             epoch_swap,
  output logic             clear_busy
);

  localparam int IDX_W  = $clog2(NUM_CTR);
  localparam int KEY_W  = TID_W + ROW_W;
  localparam int NCHUNK = (KEY_W + IDX_W - 1) / IDX_W;
  localparam int FOLD_W = NCHUNK * IDX_W;
  localparam int EC_W   = $clog2(EPOCH_ACTS);
  localparam logic [EC_W-1:0]  EPOCH_LAST = EC_W'(EPOCH_ACTS - 1);
  localparam logic [IDX_W-1:0] ADDR_LAST  = IDX_W'(NUM_CTR - 1);
  localparam logic [CTR_W-1:0] CTR_MAX    = '1;
  localparam logic [31:0]      THRESH_U   = THRESHOLD;
  localparam logic [15:0]      SEED0_INIT = 16'hACE1;
  localparam logic [15:0]      SEED1_INIT = 16'h1337;

  typedef enum logic [0:0] {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  // Rotate key left by 3k, XOR-fold into index-wide chunks, then mix seed and k.
  function automatic logic [IDX_W-1:0] hash_idx(input logic [KEY_W-1:0] key,
                                                input logic [15:0]      seed,
                                                input int               k);
    logic [KEY_W-1:0]  rot;
    logic [FOLD_W-1:0] pad;
    logic [IDX_W-1:0]  acc;
    int                r;
    r   = (3 * k) % KEY_W;
    rot = (key << r) | (key >> (KEY_W - r));
    pad = FOLD_W'(rot);
    acc = '0;
    for (int c = 0; c < NCHUNK; c++) acc = acc ^ pad[c*IDX_W +: IDX_W];
    return acc ^ seed[IDX_W-1:0] ^ IDX_W'(k);
  endfunction

  // Fibonacci LFSR, taps 16,14,13,11.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  logic                  active;
  logic [15:0]           seed [2];
  logic [CTR_W-1:0]      mem  [2][NUM_CTR];
  logic [EC_W-1:0]       epoch_cnt;
  state_t                state, state_nxt;
  logic                  clr_sel;
  logic [IDX_W-1:0]      clr_addr;
  logic                  ins_fire, swap_fire;
  logic [KEY_W-1:0]      ins_key, q_key;
  logic [NUM_CTR-1:0]    ins_hit [2];
  logic [CTR_W-1:0]      q_min, q_val;

  assign ins_key    = {ins_tid, ins_row};
  assign q_key      = {q_tid, q_row};
  assign clear_busy = (state == CLEAR);
  // Only the epoch-ending insert must wait: it would start a second clear.
  assign ins_ready  = !(clear_busy && (epoch_cnt == EPOCH_LAST));
  assign ins_fire   = ins_valid && ins_ready;
  assign swap_fire  = ins_fire && (epoch_cnt == EPOCH_LAST);

  // Per-filter set of counters touched by the current insert (collisions merge).
  always_comb begin
    for (int f = 0; f < 2; f++) begin
      ins_hit[f] = '0;
      for (int h = 0; h < NUM_HASH; h++) ins_hit[f][hash_idx(ins_key, seed[f], h)] = 1'b1;
    end
  end

  // Minimum of the active filter's counters over all hashes of the query key.
  always_comb begin
    q_min = CTR_MAX;
    q_val = '0;
    for (int h = 0; h < NUM_HASH; h++) begin
      q_val = mem[active][hash_idx(q_key, seed[active], h)];
      if (q_val < q_min) q_min = q_val;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state: clear runs once across every counter address.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (swap_fire) state_nxt = CLEAR;
      CLEAR:   if (clr_addr == ADDR_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Clear sweep address and latch of which filter is being cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_addr <= '0;
      clr_sel  <= 1'b0;
    end else if (state == IDLE) begin
      clr_addr <= '0;
      if (swap_fire) clr_sel <= active;
    end else begin
      clr_addr <= clr_addr + 1'b1;
    end
  end

  // Epoch counting, role swap and reseeding of the filter about to be cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      active     <= 1'b0;
      epoch_cnt  <= '0;
      epoch_swap <= 1'b0;
      seed[0]    <= SEED0_INIT;
      seed[1]    <= SEED1_INIT;
    end else begin
      epoch_swap <= swap_fire;
      if (swap_fire) begin
        active    <= ~active;
        epoch_cnt <= '0;
        for (int f = 0; f < 2; f++)
          if (active == 1'(f)) seed[f] <= lfsr_next(seed[f]);
      end else if (ins_fire) begin
        epoch_cnt <= epoch_cnt + 1'b1;
      end
    end
  end

  // Counter arrays: clearing filter zeroes one slot per cycle, others count inserts.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int f = 0; f < 2; f++)
        for (int i = 0; i < NUM_CTR; i++) mem[f][i] <= '0;
    end else begin
      for (int f = 0; f < 2; f++) begin
        for (int i = 0; i < NUM_CTR; i++) begin
          if (clear_busy && (clr_sel == 1'(f))) begin
            if (clr_addr == IDX_W'(i)) mem[f][i] <= '0;
          end else if (ins_fire && ins_hit[f][i] && (mem[f][i] != CTR_MAX)) begin
            mem[f][i] <= mem[f][i] + 1'b1;
          end
        end
      end
    end
  end

  // Query response, one cycle after the request.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_count <= '0;
    end else begin
      resp_valid <= q_valid;
      if (q_valid) begin
        resp_count <= q_min;
        resp_hit   <= (32'(q_min) >= THRESH_U);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dual_cbf_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_dual_cbf_tracker                                             |
// | Purpose  : Directed, table-driven bench for dual_cbf_tracker.              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_dual_cbf_tracker;

  localparam int ROW_W = 16;
  localparam int TID_W = 3;
  localparam int NCTR  = 16;
  localparam int CTR_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic             a_ins_valid, a_ins_ready, a_q_valid;
  logic [ROW_W-1:0] a_ins_row, a_q_row;
  logic [TID_W-1:0] a_ins_tid, a_q_tid;
  logic             a_resp_valid, a_resp_hit, a_epoch_swap, a_clear_busy;
  logic [CTR_W-1:0] a_resp_count;

  logic             b_ins_valid, b_ins_ready, b_q_valid;
  logic [ROW_W-1:0] b_ins_row, b_q_row;
  logic [TID_W-1:0] b_ins_tid, b_q_tid;
  logic             b_resp_valid, b_resp_hit, b_epoch_swap, b_clear_busy;
  logic [CTR_W-1:0] b_resp_count;

  dual_cbf_tracker #(.ROW_W(ROW_W), .TID_W(TID_W), .NUM_CTR(NCTR), .CTR_W(CTR_W),
                     .NUM_HASH(2), .THRESHOLD(3), .EPOCH_ACTS(8)) dut_a (
    .clk(clk), .rst(rst),
    .ins_valid(a_ins_valid), .ins_ready(a_ins_ready), .ins_row(a_ins_row), .ins_tid(a_ins_tid),
    .q_valid(a_q_valid), .q_row(a_q_row), .q_tid(a_q_tid),
    .resp_valid(a_resp_valid), .resp_hit(a_resp_hit), .resp_count(a_resp_count),
    .epoch_swap(a_epoch_swap), .clear_busy(a_clear_busy)
  );

  dual_cbf_tracker #(.ROW_W(ROW_W), .TID_W(TID_W), .NUM_CTR(NCTR), .CTR_W(CTR_W),
                     .NUM_HASH(2), .THRESHOLD(3), .EPOCH_ACTS(64)) dut_b (
    .clk(clk), .rst(rst),
    .ins_valid(b_ins_valid), .ins_ready(b_ins_ready), .ins_row(b_ins_row), .ins_tid(b_ins_tid),
    .q_valid(b_q_valid), .q_row(b_q_row), .q_tid(b_q_tid),
    .resp_valid(b_resp_valid), .resp_hit(b_resp_hit), .resp_count(b_resp_count),
    .epoch_swap(b_epoch_swap), .clear_busy(b_clear_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             iv;
    logic [ROW_W-1:0] irow;
    logic [TID_W-1:0] itid;
    logic             qv;
    logic [ROW_W-1:0] qrow;
    logic [TID_W-1:0] qtid;
    logic             e_rv;
    logic [CTR_W-1:0] e_cnt;
    logic             e_hit;
  } vec_t;

  vec_t vecs [7];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock and land just after the edge, where outputs are sampled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_all();
    rst = 1'b1;
    a_ins_valid = 1'b0; a_q_valid = 1'b0;
    b_ins_valid = 1'b0; b_q_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic int nonzero_count(input int f);
    int n;
    n = 0;
    for (int i = 0; i < NCTR; i++) if (dut_a.mem[f][i] != '0) n++;
    return n;
  endfunction

  initial begin
    int  acc, busy;
    bit  done;

    a_ins_row = '0; a_ins_tid = '0; a_q_row = '0; a_q_tid = '0;
    b_ins_row = '0; b_ins_tid = '0; b_q_row = '0; b_q_tid = '0;

    // Row 5/tid 1 lands on F0 slots {5,11}; row 0/tid 0 on {1,0}; row 5/tid 2 on {6,8}.
    vecs[0] = '{1'b1, 16'd5, 3'd1, 1'b0, 16'd0, 3'd0, 1'b0, 4'd0, 1'b0};
    vecs[1] = '{1'b1, 16'd5, 3'd1, 1'b1, 16'd5, 3'd1, 1'b1, 4'd1, 1'b0};
    vecs[2] = '{1'b0, 16'd0, 3'd0, 1'b1, 16'd5, 3'd1, 1'b1, 4'd2, 1'b0};
    vecs[3] = '{1'b1, 16'd5, 3'd1, 1'b1, 16'd0, 3'd0, 1'b1, 4'd0, 1'b0};
    vecs[4] = '{1'b0, 16'd0, 3'd0, 1'b1, 16'd5, 3'd1, 1'b1, 4'd3, 1'b1};
    vecs[5] = '{1'b0, 16'd0, 3'd0, 1'b1, 16'd5, 3'd2, 1'b1, 4'd0, 1'b0};
    vecs[6] = '{1'b0, 16'd0, 3'd0, 1'b0, 16'd0, 3'd0, 1'b0, 4'd0, 1'b0};

    reset_all();
    chk("rst_resp_valid", 32'(a_resp_valid), 0);
    chk("rst_resp_hit",   32'(a_resp_hit),   0);
    chk("rst_resp_count", 32'(a_resp_count), 0);
    chk("rst_epoch_swap", 32'(a_epoch_swap), 0);
    chk("rst_clear_busy", 32'(a_clear_busy), 0);
    chk("rst_ins_ready",  32'(a_ins_ready),  1);
    chk("rst_seed0",      32'(dut_a.seed[0]), 32'hACE1);
    chk("rst_seed1",      32'(dut_a.seed[1]), 32'h1337);

    // Table-driven insert/query vectors; response checked after the capturing edge.
    for (int i = 0; i < 7; i++) begin
      a_ins_valid = vecs[i].iv; a_ins_row = vecs[i].irow; a_ins_tid = vecs[i].itid;
      a_q_valid   = vecs[i].qv; a_q_row   = vecs[i].qrow; a_q_tid   = vecs[i].qtid;
      step();
      chk($sformatf("vec%0d_resp_valid", i), 32'(a_resp_valid), 32'(vecs[i].e_rv));
      if (vecs[i].e_rv) begin
        chk($sformatf("vec%0d_resp_count", i), 32'(a_resp_count), 32'(vecs[i].e_cnt));
        chk($sformatf("vec%0d_resp_hit", i),   32'(a_resp_hit),   32'(vecs[i].e_hit));
      end
    end
    a_ins_valid = 1'b0; a_q_valid = 1'b0;

    // Saturation: 20 inserts into a 4-bit counter with a long epoch.
    b_ins_valid = 1'b1; b_ins_row = 16'd5; b_ins_tid = 3'd1;
    for (int i = 0; i < 20; i++) step();
    b_ins_valid = 1'b0;
    b_q_valid = 1'b1; b_q_row = 16'd5; b_q_tid = 3'd1;
    step();
    b_q_valid = 1'b0;
    chk("sat_resp_valid", 32'(b_resp_valid), 1);
    chk("sat_resp_count", 32'(b_resp_count), 15);
    chk("sat_resp_hit",   32'(b_resp_hit),   1);
    chk("sat_epoch_swap", 32'(b_epoch_swap), 0);

    // Epoch swap, clear window and back-pressure with continuous inserts.
    reset_all();
    a_ins_valid = 1'b1; a_ins_row = 16'h0100; a_ins_tid = 3'd2;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("pre_swap_pulse", 32'(a_epoch_swap), 0);
      chk("pre_swap_busy",  32'(a_clear_busy), 0);
    end
    step();
    chk("swap_pulse",     32'(a_epoch_swap), 1);
    chk("swap_busy",      32'(a_clear_busy), 1);
    chk("swap_active",    32'(dut_a.active), 1);
    chk("swap_seed0_adv", 32'(dut_a.seed[0]), 32'h59C3);
    chk("swap_seed1_kept", 32'(dut_a.seed[1]), 32'h1337);
    chk("f0_loaded",      32'(nonzero_count(0) > 0), 1);

    acc = 0; busy = 1; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      chk("ready_in_clear", 32'(a_ins_ready), (acc == 7) ? 0 : 1);
      if (a_ins_ready) acc++;
      step();
      if (a_clear_busy) begin
        busy++;
        chk("swap_pulse_width", 32'(a_epoch_swap), 0);
      end else begin
        done = 1'b1;
      end
    end
    chk("clear_ended",       32'(done), 1);
    chk("clear_busy_cycles", 32'(busy), 16);
    chk("inserts_in_clear",  32'(acc),  7);
    chk("ready_released",    32'(a_ins_ready), 1);
    chk("f0_cleared",        32'(nonzero_count(0)), 0);

    // F1 saw 8 + 7 inserts; same-cycle insert must not show up in this response.
    a_q_valid = 1'b1; a_q_row = 16'h0100; a_q_tid = 3'd2;
    step();
    a_q_valid = 1'b0; a_ins_valid = 1'b0;
    chk("f1_resp_count",   32'(a_resp_count), 15);
    chk("f1_resp_hit",     32'(a_resp_hit),   1);
    chk("second_swap",     32'(a_epoch_swap), 1);
    chk("second_swap_act", 32'(dut_a.active), 0);

    // Reset in the middle of a clear.
    reset_all();
    a_ins_valid = 1'b1; a_ins_row = 16'h0042; a_ins_tid = 3'd5;
    for (int i = 0; i < 8; i++) step();
    for (int i = 0; i < 4; i++) step();
    chk("mid_clear_busy", 32'(a_clear_busy), 1);
    rst = 1'b1; a_ins_valid = 1'b0;
    step();
    chk("abort_busy",   32'(a_clear_busy), 0);
    chk("abort_active", 32'(dut_a.active), 0);
    chk("abort_seed0",  32'(dut_a.seed[0]), 32'hACE1);
    chk("abort_seed1",  32'(dut_a.seed[1]), 32'h1337);
    chk("abort_f0_zero", 32'(nonzero_count(0)), 0);
    chk("abort_f1_zero", 32'(nonzero_count(1)), 0);
    chk("abort_ready",  32'(a_ins_ready), 1);
    chk("abort_swap",   32'(a_epoch_swap), 0);
    rst = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
